// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline types: opcode constants, shadow-stage record, forwarding
// select and hazard FSM encodings, plus the forwarding priority helper.
package cpu_pkg;

   localparam logic [10:0] OP_LDUR  = 11'b11111000010;
   localparam logic [10:0] OP_STUR  = 11'b11111000000;
   localparam logic [10:0] OP_ADD   = 11'b10001011000;
   localparam logic [10:0] OP_SUB   = 11'b11001011000;
   localparam logic [10:0] OP_ADDS  = 11'b10101011000;
   localparam logic [10:0] OP_SUBS  = 11'b11101011000;
   localparam logic [10:0] OP_AND   = 11'b10001010000;
   localparam logic [10:0] OP_ORR   = 11'b10101010000;
   localparam logic [10:0] OP_EOR   = 11'b11001010000;
   localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
   localparam logic [7:0]  OP_CBZ   = 8'b10110100;
   localparam logic [7:0]  OP_BCOND = 8'b01010100;
   localparam logic [5:0]  OP_B     = 6'b000101;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_MEMWB = 2'b01,
      FWD_EXMEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } stage_info_t;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } hz_state_e;

   localparam stage_info_t STAGE_EMPTY = '{valid: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};

   // The youngest producer wins: EX/MEM result beats MEM/WB data.
   function automatic fwd_sel_e fwd_pick(input stage_info_t ex,
                                         input stage_info_t mem,
                                         input logic [4:0]  src,
                                         input logic        use_src);
      fwd_sel_e sel;
      if (use_src && ex.valid && ex.wr && (ex.rd == src)) begin
         sel = FWD_EXMEM;
      end else if (use_src && mem.valid && mem.wr && (mem.rd == src)) begin
         sel = FWD_MEMWB;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hz_decode.sv
// Combinational LEGv8 register-usage decode for the instruction held in IF/ID.
module hz_decode
   import cpu_pkg::*;
#(
   parameter int unsigned ZERO_REG = 31
) (
   input  logic [31:0] instr_i,
   output logic [4:0]  src1_o,
   output logic        use1_o,
   output logic [4:0]  src2_o,
   output logic        use2_o,
   output logic [4:0]  dest_o,
   output logic        wr_o,
   output logic        ld_o
);

   localparam logic [4:0] ZR_IDX = ZERO_REG[4:0];

   logic [10:0] op11_s;
   logic        use1_raw_s;
   logic        use2_raw_s;
   logic        wr_raw_s;
   logic        ld_raw_s;
   logic        imm_unused_s;

   assign op11_s       = instr_i[31:21];
   assign imm_unused_s = ^instr_i[15:10];

   // Register fields by format; B and B.cond fall through as using and writing nothing.
   always_comb begin
      src1_o     = instr_i[9:5];
      src2_o     = instr_i[20:16];
      dest_o     = instr_i[4:0];
      use1_raw_s = 1'b0;
      use2_raw_s = 1'b0;
      wr_raw_s   = 1'b0;
      ld_raw_s   = 1'b0;
      if (op11_s inside {OP_ADD, OP_SUB, OP_ADDS, OP_SUBS, OP_AND, OP_ORR, OP_EOR}) begin
         use1_raw_s = 1'b1;
         use2_raw_s = 1'b1;
         wr_raw_s   = 1'b1;
      end else if (op11_s == OP_LDUR) begin
         use1_raw_s = 1'b1;
         wr_raw_s   = 1'b1;
         ld_raw_s   = 1'b1;
      end else if (op11_s == OP_STUR) begin
         use1_raw_s = 1'b1;
         use2_raw_s = 1'b1;
         src2_o     = instr_i[4:0];
      end else if (instr_i[31:22] == OP_ADDI) begin
         use1_raw_s = 1'b1;
         wr_raw_s   = 1'b1;
      end else if (instr_i[31:24] == OP_CBZ) begin
         use2_raw_s = 1'b1;
         src2_o     = instr_i[4:0];
      end else begin
         use1_raw_s = 1'b0;
      end
   end

   assign use1_o = use1_raw_s & (src1_o != ZR_IDX);
   assign use2_o = use2_raw_s & (src2_o != ZR_IDX);
   assign wr_o   = wr_raw_s & (dest_o != ZR_IDX);
   assign ld_o   = ld_raw_s & wr_o;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage LEGv8 pipeline: load-use stalls,
// taken-branch flushes and registered EX-stage forwarding selects.
module pipe_hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      id_instr,
   input  logic             id_valid,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [4:0]       dec_src1_s;
   logic [4:0]       dec_src2_s;
   logic [4:0]       dec_dest_s;
   logic             dec_use1_s;
   logic             dec_use2_s;
   logic             dec_wr_s;
   logic             dec_ld_s;
   logic             use1_s;
   logic             use2_s;
   logic             load_use_s;
   logic             flush_s;
   logic             stall_s;
   stage_info_t      ex_q, ex_d;
   stage_info_t      mem_q;
   stage_info_t      wb_q;
   hz_state_e        state_q, state_d;
   fwd_sel_e         fwd_a_q, fwd_a_d;
   fwd_sel_e         fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             wb_unused_s;

   hz_decode #(.ZERO_REG(ZERO_REG)) u_decode (
      .instr_i (id_instr),
      .src1_o  (dec_src1_s),
      .use1_o  (dec_use1_s),
      .src2_o  (dec_src2_s),
      .use2_o  (dec_use2_s),
      .dest_o  (dec_dest_s),
      .wr_o    (dec_wr_s),
      .ld_o    (dec_ld_s)
   );

   assign use1_s = dec_use1_s & id_valid;
   assign use2_s = dec_use2_s & id_valid;

   // WB is tracked for completeness; regfile write-then-read already covers it.
   assign wb_unused_s = ^wb_q;

   // Hazard detection; a taken branch overrides any load-use stall.
   always_comb begin
      load_use_s = 1'b0;
      if (ex_q.valid && ex_q.ld && (state_q != STALL)) begin
         load_use_s = (use1_s && (ex_q.rd == dec_src1_s)) ||
                      (use2_s && (ex_q.rd == dec_src2_s));
      end else begin
         load_use_s = 1'b0;
      end
      flush_s = branch_taken;
      stall_s = load_use_s & ~flush_s;
   end

   // Pipeline-register controls respond in the same cycle.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (flush_s) begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall_s) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b1;
      end else begin
         pc_write    = 1'b1;
         ifid_write  = 1'b1;
         ifid_flush  = 1'b0;
         idex_bubble = 1'b0;
      end
   end

   // Next state: FSM, EX shadow entry, forwarding selects and saturating counters.
   always_comb begin
      state_d     = RUN;
      ex_d        = STAGE_EMPTY;
      fwd_a_d     = FWD_RF;
      fwd_b_d     = FWD_RF;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (flush_s) begin
         state_d = FLUSH;
      end else if (stall_s) begin
         state_d = STALL;
      end else begin
         state_d = RUN;
         ex_d    = '{valid: id_valid, rd: dec_dest_s,
                     wr: dec_wr_s & id_valid, ld: dec_ld_s & id_valid};
         fwd_a_d = fwd_pick(ex_q, mem_q, dec_src1_s, use1_s);
         fwd_b_d = fwd_pick(ex_q, mem_q, dec_src2_s, use2_s);
      end
      if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush_s && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         ex_q        <= STAGE_EMPTY;
         mem_q       <= STAGE_EMPTY;
         wb_q        <= STAGE_EMPTY;
         fwd_a_q     <= FWD_RF;
         fwd_b_q     <= FWD_RF;
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         mem_q       <= ex_q;
         wb_q        <= mem_q;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against an instruction-level
// pipeline occupancy model; a 2-bit-counter instance exercises saturation.
module tb_pipe_hazard_ctrl;

   localparam logic [10:0] T_LDUR = 11'b11111000010;
   localparam logic [10:0] T_STUR = 11'b11111000000;
   localparam logic [10:0] T_ADD  = 11'b10001011000;
   localparam logic [10:0] T_SUB  = 11'b11001011000;
   localparam logic [10:0] T_SUBS = 11'b11101011000;
   localparam logic [10:0] T_ORR  = 11'b10101010000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        branch_taken;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
   logic [1:0]  s_fwd_a, s_fwd_b;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
      .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
      .branch_taken(branch_taken), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
      .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   // An instruction as the model sees it: sources (-2 = none), destination (-1 = none).
   typedef struct {
      logic [31:0] instr;
      int          s1;
      int          s2;
      int          dst;
      bit          ld;
      bit          v;
      bit          bt;
   } ins_t;

   ins_t q[$];
   ins_t id_cur;
   int   p_dst[3];
   bit   p_ld[3];
   int   m_fa, m_fb, m_sc, m_fc, m_sc2, m_fc2;
   bit   last_stall;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int src_of(input int r);
      return (r == 31) ? -2 : r;
   endfunction

   function automatic int dst_of(input int r);
      return (r == 31) ? -1 : r;
   endfunction

   function automatic ins_t bubble();
      ins_t t;
      t.instr = 32'd0; t.s1 = -2; t.s2 = -2; t.dst = -1; t.ld = 1'b0; t.v = 1'b0; t.bt = 1'b0;
      return t;
   endfunction

   function automatic ins_t mk_r(input logic [10:0] op, input int rd, input int rn, input int rm, input bit bt);
      ins_t t = bubble();
      t.instr = {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
      t.s1 = src_of(rn); t.s2 = src_of(rm); t.dst = dst_of(rd); t.v = 1'b1; t.bt = bt;
      return t;
   endfunction

   function automatic ins_t mk_ldur(input int rt, input int rn, input bit bt);
      ins_t t = bubble();
      t.instr = {T_LDUR, 9'($urandom), 2'b00, 5'(rn), 5'(rt)};
      t.s1 = src_of(rn); t.dst = dst_of(rt); t.ld = 1'b1; t.v = 1'b1; t.bt = bt;
      return t;
   endfunction

   function automatic int rnd_reg();
      int r = int'($urandom_range(0, 4));
      return (r == 4) ? 31 : r;
   endfunction

   function automatic ins_t gen();
      ins_t t = bubble();
      int   k = int'($urandom_range(0, 9));
      int   a = rnd_reg();
      int   b = rnd_reg();
      int   c = rnd_reg();
      bit   bt = ($urandom_range(0, 7) == 0);
      case (k)
         0, 1: t = mk_ldur(a, b, bt);
         2:    t = mk_r(T_ADD, a, b, c, bt);
         3:    t = mk_r(T_SUBS, a, b, c, bt);
         4:    t = mk_r(T_ORR, a, b, c, bt);
         5: begin
            t.instr = {10'b1001000100, 12'($urandom), 5'(b), 5'(a)};
            t.s1 = src_of(b); t.dst = dst_of(a); t.v = 1'b1; t.bt = bt;
         end
         6: begin
            t.instr = {T_STUR, 9'($urandom), 2'b00, 5'(b), 5'(a)};
            t.s1 = src_of(b); t.s2 = src_of(a); t.v = 1'b1; t.bt = bt;
         end
         7: begin
            t.instr = {8'b10110100, 19'($urandom), 5'(a)};
            t.s2 = src_of(a); t.v = 1'b1; t.bt = bt;
         end
         8: begin
            t.instr = ($urandom_range(0, 1) == 0) ? {6'b000101, 26'($urandom)}
                                                 : {8'b01010100, 19'($urandom), 5'($urandom)};
            t.v = 1'b1; t.bt = bt;
         end
         default: begin
            t = mk_r(T_ADD, a, b, c, bt);
            t.v = 1'b0;
         end
      endcase
      return t;
   endfunction

   function automatic int fwd_exp(input int s);
      if (s >= 0 && p_dst[0] == s) return 2;
      if (s >= 0 && p_dst[1] == s) return 1;
      return 0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         p_dst[i] = -1;
         p_ld[i]  = 1'b0;
      end
      m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
      last_stall = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #1;
      chk_eq("rst_pc_write", pc_write, 32'd0);
      chk_eq("rst_ifid_write", ifid_write, 32'd0);
      chk_eq("rst_ifid_flush", ifid_flush, 32'd1);
      chk_eq("rst_idex_bubble", idex_bubble, 32'd1);
      chk_eq("rst_fwd_a", fwd_a, 32'd0);
      chk_eq("rst_fwd_b", fwd_b, 32'd0);
      chk_eq("rst_stall_cnt", stall_cnt, 32'd0);
      chk_eq("rst_flush_cnt", flush_cnt, 32'd0);
      model_clear();
      q.delete();
      id_cur = bubble();
      id_instr = 32'd0; id_valid = 1'b0; branch_taken = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_cycle();
      int s1, s2, nfa, nfb;
      bit lu, fl, st;
      @(negedge clk);
      id_instr     = id_cur.instr;
      id_valid     = id_cur.v;
      branch_taken = id_cur.bt;
      #1;
      s1 = id_cur.v ? id_cur.s1 : -2;
      s2 = id_cur.v ? id_cur.s2 : -2;
      lu = p_ld[0] && (p_dst[0] >= 0) && (p_dst[0] == s1 || p_dst[0] == s2);
      fl = id_cur.bt;
      st = lu && !fl;
      chk_eq("pc_write", pc_write, {31'd0, !st});
      chk_eq("ifid_write", ifid_write, {31'd0, !st});
      chk_eq("ifid_flush", ifid_flush, {31'd0, fl});
      chk_eq("idex_bubble", idex_bubble, {31'd0, st || fl});
      chk_eq("fwd_a", fwd_a, 32'(m_fa));
      chk_eq("fwd_b", fwd_b, 32'(m_fb));
      chk_eq("stall_cnt", stall_cnt, 32'(m_sc));
      chk_eq("flush_cnt", flush_cnt, 32'(m_fc));
      chk_eq("sat_stall_cnt", s_stall_cnt, 32'(m_sc2));
      chk_eq("sat_flush_cnt", s_flush_cnt, 32'(m_fc2));
      nfa = fwd_exp(s1);
      nfb = fwd_exp(s2);
      m_fa = (st || fl) ? 0 : nfa;
      m_fb = (st || fl) ? 0 : nfb;
      p_dst[2] = p_dst[1]; p_ld[2] = p_ld[1];
      p_dst[1] = p_dst[0]; p_ld[1] = p_ld[0];
      p_dst[0] = (st || fl || !id_cur.v) ? -1 : id_cur.dst;
      p_ld[0]  = (st || fl || !id_cur.v) ? 1'b0 : id_cur.ld;
      if (st) begin
         if (m_sc < 65535) m_sc++;
         if (m_sc2 < 3) m_sc2++;
      end
      if (fl) begin
         if (m_fc < 65535) m_fc++;
         if (m_fc2 < 3) m_fc2++;
      end
      last_stall = st;
      if (st) begin
         id_cur.bt = 1'b0;
      end else if (fl) begin
         id_cur = bubble();
      end else begin
         id_cur = (q.size() > 0) ? q.pop_front() : bubble();
      end
   endtask

   task automatic drain();
      while (q.size() > 0 || id_cur.v) run_cycle();
      repeat (3) run_cycle();
   endtask

   initial begin
      reset = 1'b0; id_instr = 32'd0; id_valid = 1'b0; branch_taken = 1'b0;
      id_cur = bubble();
      apply_reset();

      // Load-use stall, then MEM/WB forward of the loaded value.
      q.push_back(mk_ldur(1, 2, 1'b0));
      q.push_back(mk_r(T_ADD, 3, 1, 4, 1'b0));
      drain();
      chk_eq("t1_stall_cnt", stall_cnt, 32'd1);

      q.push_back(mk_r(T_ADD, 1, 2, 3, 1'b0));
      q.push_back(mk_r(T_SUB, 5, 1, 1, 1'b0));
      drain();

      q.push_back(mk_r(T_ADD, 1, 2, 3, 1'b0));
      q.push_back(mk_r(T_ORR, 7, 2, 3, 1'b0));
      q.push_back(mk_r(T_SUB, 6, 1, 8, 1'b0));
      drain();
      q.push_back(mk_r(T_ADD, 31, 2, 3, 1'b0));
      q.push_back(mk_r(T_ORR, 7, 2, 3, 1'b0));
      q.push_back(mk_r(T_SUB, 6, 1, 8, 1'b0));
      drain();

      // Branch taken while a load-use hazard is pending: flush wins.
      q.push_back(mk_ldur(1, 2, 1'b0));
      q.push_back(mk_r(T_ADD, 3, 1, 4, 1'b1));
      drain();
      chk_eq("t4_flush_cnt", flush_cnt, 32'd1);
      chk_eq("t4_stall_cnt", stall_cnt, 32'd1);

      // Reset asserted while the FSM sits in STALL.
      q.push_back(mk_ldur(1, 2, 1'b0));
      q.push_back(mk_r(T_ADD, 3, 1, 4, 1'b0));
      for (int i = 0; i < 10 && !last_stall; i++) run_cycle();
      chk_eq("t5_stall_seen", {31'd0, last_stall}, 32'd1);
      @(negedge clk);
      id_instr = id_cur.instr; id_valid = id_cur.v; branch_taken = 1'b0;
      #2;
      apply_reset();
      q.push_back(mk_r(T_ADD, 5, 1, 2, 1'b0));
      drain();
      chk_eq("t5_stall_cnt", stall_cnt, 32'd0);

      repeat (500) begin
         if (q.size() == 0) q.push_back(gen());
         run_cycle();
      end
      drain();

      repeat (4) begin
         q.push_back(mk_ldur(1, 2, 1'b0));
         q.push_back(mk_r(T_ADD, 3, 1, 4, 1'b0));
      end
      drain();
      chk_eq("sat_stall_hold", s_stall_cnt, 32'd3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
